ft_voter: RTL

FT_VOTER -- requirements
Module: ft_voter

---
 rtl/ft_voter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ft_voter.sv
// ft_voter: DMR/TMR write-port voter with error accounting and a persistent-fault recovery FSM.
module ft_voter #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CORES      = 3,
  parameter int CNT_WIDTH      = 8,
  parameter int PERSIST_THRESH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_CORES-1:0]             we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  data_i,
  input  logic                             clr_i,
  input  logic                             recover_ack_i,
  output logic                             we_o,
  output logic [ADDR_WIDTH-1:0]            addr_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             error_o,
  output logic [NUM_CORES-1:0]             faulty_o,
  output logic                             fatal_o,
  output logic [CNT_WIDTH-1:0]             err_count_o,
  output logic                             recover_o,
  output logic [1:0]                       recover_id_o
);
  localparam int TW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] THR = CNT_WIDTH'(PERSIST_THRESH);
  typedef enum logic [1:0] {IDLE, TRACK, RECOVER} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] pcnt, pcnt_n;
  logic [1:0] fid, fid_n, fk;
  logic [TW-1:0] t [3];
  logic [TW-1:0] maj;
  logic [2:0] f3;
  logic a01, a02, a12, clean, corr, err, uncorr;
  // Missing third core in DMR is padded so the voting logic stays uniform.
  for (genvar i = 0; i < 3; i++) begin : g_t
    if (i < NUM_CORES) begin : g_in
      assign t[i] = {we_i[i], addr_i[i*ADDR_WIDTH +: ADDR_WIDTH], data_i[i*DATA_WIDTH +: DATA_WIDTH]};
    end else begin : g_pad
      assign t[i] = '0;
    end
  end
  always_comb begin
    a01    = t[0] == t[1];
    a02    = t[0] == t[2];
    a12    = t[1] == t[2];
    clean  = NUM_CORES == 3 ? a01 && a02 : a01;
    f3     = NUM_CORES != 3 || clean ? 3'b000 :
             a01 && !a02 ? 3'b100 :
             a02 && !a01 ? 3'b010 :
             a12 && !a01 ? 3'b001 : 3'b000;
    corr   = |f3;
    err    = !clean;
    uncorr = err && !corr;
    maj    = f3[0] ? t[1] : t[0];
    fk     = f3[2] ? 2'd2 : f3[1] ? 2'd1 : 2'd0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o        <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      error_o     <= 1'b0;
      faulty_o    <= '0;
      fatal_o     <= 1'b0;
      err_count_o <= '0;
    end else begin
      we_o     <= !uncorr && maj[TW-1];
      error_o  <= err;
      faulty_o <= f3[NUM_CORES-1:0];
      if (!uncorr) begin
        addr_o <= maj[TW-2 -: ADDR_WIDTH];
        data_o <= maj[DATA_WIDTH-1:0];
      end
      if (clr_i) begin
        err_count_o <= '0;
        fatal_o     <= 1'b0;
      end else begin
        if (err && err_count_o != '1) err_count_o <= err_count_o + 1'b1;
        if (uncorr) fatal_o <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      pcnt  <= '0;
      fid   <= '0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      fid   <= fid_n;
    end
  end
  // corr is never set in DMR, so the FSM cannot leave IDLE there.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    fid_n   = fid;
    case (state)
      IDLE: if (corr) begin
        fid_n   = fk;
        pcnt_n  = CNT_WIDTH'(1);
        state_n = PERSIST_THRESH == 1 ? RECOVER : TRACK;
      end
      TRACK: if (corr && fk == fid) begin
        pcnt_n = pcnt + 1'b1;
        if (pcnt_n == THR) state_n = RECOVER;
      end else if (corr) begin
        fid_n  = fk;
        pcnt_n = CNT_WIDTH'(1);
      end else begin
        state_n = IDLE;
        pcnt_n  = '0;
      end
      RECOVER: if (recover_ack_i) begin
        state_n = IDLE;
        pcnt_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  assign recover_o    = state == RECOVER;
  assign recover_id_o = fid;
endmodule
